mgmt_register_file: RTL

- Parametrised byte-addressed management register block: streaming burst reads, single-byte writes, configurable bank of 32-bit RW config registers, plus read-only device-info (IDCODE, die serial, status).
- Sits between the management bridge (simulation bridge or future SPI/Ethernet bridge) and fabric.
- Drives config registers to fabric.

---
 rtl/mgmt_regs_pkg.sv | 16 +
 rtl/mgmt_register_file_if.sv | 29 ++
 rtl/mgmt_byte_mux.sv | 62 ++++++
 rtl/mgmt_register_file.sv | 156 +++++++++++++++
 4 files changed

// File: rtl/mgmt_regs_pkg.sv
// Shared address map constants and read-FSM state type for the management register block.
package mgmt_regs_pkg;

  localparam int unsigned ADDR_IDCODE  = 32'h00;
  localparam int unsigned ADDR_SERIAL  = 32'h04;
  localparam int unsigned ADDR_STATUS  = 32'h0C;
  localparam int unsigned ADDR_NREGS   = 32'h0D;
  localparam int unsigned ADDR_RW_BASE = 32'h10;

  typedef enum logic [1:0] {
    RD_IDLE,
    RD_RUN,
    RD_DRAIN
  } rd_state_t;

endpackage

// File: rtl/mgmt_register_file_if.sv
// Burst-read / byte-write bus between the management bridge (master) and the register file (slave).
interface mgmt_register_file_if #(
  parameter int ADDR_WIDTH = 16
) ();

  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [15:0]           rd_len;
  logic                  rd_busy;
  logic                  rd_valid;
  logic [7:0]            rd_data;
  logic                  rd_done;
  logic                  rd_err;
  logic                  wr_en;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [7:0]            wr_data;
  logic                  wr_err;

  modport master (
    output rd_en, rd_addr, rd_len, wr_en, wr_addr, wr_data,
    input  rd_busy, rd_valid, rd_data, rd_done, rd_err, wr_err
  );

  modport slave (
    input  rd_en, rd_addr, rd_len, wr_en, wr_addr, wr_data,
    output rd_busy, rd_valid, rd_data, rd_done, rd_err, wr_err
  );

endinterface

// File: rtl/mgmt_byte_mux.sv
// Combinational address decode: returns the byte at addr, its stall condition,
// and whether the address is mapped / writable (with the RW bit offset).
module mgmt_byte_mux
  import mgmt_regs_pkg::*;
#(
  parameter int ADDR_WIDTH  = 16,
  parameter int NUM_RW_REGS = 8
) (
  input  logic [ADDR_WIDTH-1:0]    addr,
  input  logic                     idcode_valid,
  input  logic [31:0]              idcode,
  input  logic                     die_serial_valid,
  input  logic [63:0]              die_serial,
  input  logic [NUM_RW_REGS*32-1:0] cfg_regs,
  output logic [7:0]               byte_data,
  output logic                     stall,
  output logic                     mapped,
  output logic                     writable,
  output logic [10:0]              rw_bit
);

  localparam int unsigned RW_END = ADDR_RW_BASE + 32'(4 * NUM_RW_REGS);

  logic [31:0] a;
  logic [2:0]  ser_off;
  logic [7:0]  rw_off;

  assign a       = 32'(addr);
  assign ser_off = 3'(a - ADDR_SERIAL);
  assign rw_off  = 8'(a - ADDR_RW_BASE);
  // rw_off = 4*reg + byte, so rw_off*8 is the bit offset into cfg_regs
  assign rw_bit  = {rw_off, 3'b000};

  always_comb begin
    byte_data = 8'h00;
    stall     = 1'b0;
    mapped    = 1'b0;
    writable  = 1'b0;
    if (a < ADDR_SERIAL) begin
      byte_data = idcode[{a[1:0], 3'b000} +: 8];
      stall     = !idcode_valid;
      mapped    = 1'b1;
    end else if (a < ADDR_STATUS) begin
      byte_data = die_serial[{ser_off, 3'b000} +: 8];
      stall     = !die_serial_valid;
      mapped    = 1'b1;
    end else if (a == ADDR_STATUS) begin
      byte_data = {6'b0, die_serial_valid, idcode_valid};
      mapped    = 1'b1;
    end else if (a == ADDR_NREGS) begin
      byte_data = 8'(NUM_RW_REGS);
      mapped    = 1'b1;
    end else if (a < ADDR_RW_BASE) begin
      mapped    = 1'b1;
    end else if (a < RW_END) begin
      byte_data = cfg_regs[rw_bit +: 8];
      mapped    = 1'b1;
      writable  = 1'b1;
    end
  end

endmodule

// File: rtl/mgmt_register_file.sv
// Management register file: streaming burst reads, single-byte writes to RW config regs.
// state    | meaning
// RD_IDLE  | waiting for rd_en
// RD_RUN   | issuing one byte per cycle (holds on stall)
// RD_DRAIN | last byte and rd_done presented, back to idle next
module mgmt_register_file
  import mgmt_regs_pkg::*;
#(
  parameter int                        ADDR_WIDTH  = 16,
  parameter int                        NUM_RW_REGS = 8,
  parameter logic [NUM_RW_REGS*32-1:0] RW_RESET    = '0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  mgmt_register_file_if.slave       bus,
  input  logic                      idcode_valid,
  input  logic [31:0]               idcode,
  input  logic                      die_serial_valid,
  input  logic [63:0]               die_serial,
  output logic [NUM_RW_REGS*32-1:0] cfg_regs
);

  rd_state_t                 state_q, state_d;
  logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
  logic [15:0]               len_q, len_d;
  logic                      busy_q, busy_d;
  logic                      valid_q, valid_d;
  logic [7:0]                data_q, data_d;
  logic                      done_q, done_d;
  logic                      rd_err_q, rd_err_d;
  logic                      wr_err_q, wr_err_d;
  logic [NUM_RW_REGS*32-1:0] cfg_q, cfg_d;

  logic [7:0]  rd_byte, wr_byte;
  logic        rd_stall, wr_stall;
  logic        rd_mapped, wr_mapped, rd_writable, wr_writable;
  logic [10:0] rd_rw_bit, wr_rw_bit;
  logic        unused_mux;

  mgmt_byte_mux #(.ADDR_WIDTH(ADDR_WIDTH), .NUM_RW_REGS(NUM_RW_REGS)) u_rd_mux (
    .addr             (addr_q),
    .idcode_valid     (idcode_valid),
    .idcode           (idcode),
    .die_serial_valid (die_serial_valid),
    .die_serial       (die_serial),
    .cfg_regs         (cfg_q),
    .byte_data        (rd_byte),
    .stall            (rd_stall),
    .mapped           (rd_mapped),
    .writable         (rd_writable),
    .rw_bit           (rd_rw_bit)
  );

  mgmt_byte_mux #(.ADDR_WIDTH(ADDR_WIDTH), .NUM_RW_REGS(NUM_RW_REGS)) u_wr_mux (
    .addr             (bus.wr_addr),
    .idcode_valid     (idcode_valid),
    .idcode           (idcode),
    .die_serial_valid (die_serial_valid),
    .die_serial       (die_serial),
    .cfg_regs         (cfg_q),
    .byte_data        (wr_byte),
    .stall            (wr_stall),
    .mapped           (wr_mapped),
    .writable         (wr_writable),
    .rw_bit           (wr_rw_bit)
  );

  assign unused_mux = ^{rd_mapped, rd_writable, rd_rw_bit, wr_byte, wr_stall, wr_mapped};

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    len_d    = len_q;
    busy_d   = busy_q;
    valid_d  = 1'b0;
    data_d   = data_q;
    done_d   = 1'b0;
    rd_err_d = bus.rd_en && busy_q;
    case (state_q)
      RD_IDLE: begin
        if (bus.rd_en) begin
          if (bus.rd_len != 16'd0) begin
            addr_d  = bus.rd_addr;
            len_d   = bus.rd_len;
            busy_d  = 1'b1;
            state_d = RD_RUN;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      RD_RUN: begin
        if (!rd_stall) begin
          valid_d = 1'b1;
          data_d  = rd_byte;
          addr_d  = addr_q + ADDR_WIDTH'(1);
          len_d   = len_q - 16'd1;
          if (len_q == 16'd1) begin
            done_d  = 1'b1;
            state_d = RD_DRAIN;
          end
        end
      end
      RD_DRAIN: begin
        busy_d  = 1'b0;
        state_d = RD_IDLE;
      end
      default: state_d = RD_IDLE;
    endcase
  end

  // Writes run independently of the read FSM; the read mux sees the old value this cycle.
  always_comb begin
    cfg_d    = cfg_q;
    wr_err_d = 1'b0;
    if (bus.wr_en) begin
      if (wr_writable) cfg_d[wr_rw_bit +: 8] = bus.wr_data;
      else             wr_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RD_IDLE;
      addr_q   <= '0;
      len_q    <= '0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      data_q   <= 8'h00;
      done_q   <= 1'b0;
      rd_err_q <= 1'b0;
      wr_err_q <= 1'b0;
      cfg_q    <= RW_RESET;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      len_q    <= len_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
      done_q   <= done_d;
      rd_err_q <= rd_err_d;
      wr_err_q <= wr_err_d;
      cfg_q    <= cfg_d;
    end
  end

  assign bus.rd_busy  = busy_q;
  assign bus.rd_valid = valid_q;
  assign bus.rd_data  = data_q;
  assign bus.rd_done  = done_q;
  assign bus.rd_err   = rd_err_q;
  assign bus.wr_err   = wr_err_q;
  assign cfg_regs     = cfg_q;

endmodule
